hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: pipeline stall/flush controller with data-memory wait FSM,
// sticky wait-timeout flag and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic [1:0] ID_PCSrc,
  input  logic       EX_MemRead,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_WriteReg,
  input  logic       EX_BranchTaken,
  input  logic       MEM_MemRead,
  input  logic       MEM_MemWrite,
  input  logic       dmem_ready,
  output logic       PC_write,
  output logic       IFID_write,
  output logic       IDEX_write,
  output logic       EXMEM_write,
  output logic       IFID_flush,
  output logic       IDEX_flush,
  output logic       MEMWB_bubble,
  output logic       mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic mem_req;
  logic load_use;
  logic jr_hazard;

  assign mem_req = MEM_MemRead | MEM_MemWrite;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        // Once in the wait, only dmem_ready or the timeout can end it.
        if (dmem_ready) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TIMEOUT_C) begin
          mem_timeout_d = 1'b1;
          state_d       = RUN;
          wcnt_d        = 8'd0;
        end else begin
          freeze = 1'b1;
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                    ((ID_uses_rs && (EX_WriteReg == ID_rs)) ||
                     (ID_uses_rt && (EX_WriteReg == ID_rt)));

  assign jr_hazard = (ID_PCSrc == 2'd2) && EX_RegWrite &&
                     (EX_WriteReg != 5'd0) && (EX_WriteReg == ID_rs);

  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_write   = 1'b1;
    EXMEM_write  = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    MEMWB_bubble = 1'b0;
    if (freeze) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEX_write   = 1'b0;
      EXMEM_write  = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (load_use || jr_hazard) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IDEX_flush = 1'b1;
    end else if (ID_PCSrc != 2'd0) begin
      IFID_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_write && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (IFID_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      wcnt_q        <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// tb_hazard_ctrl: table-driven single-cycle vectors plus hand-written
// sequences for memory wait, timeout, jr stall, saturation and async reset.
module tb_hazard_ctrl;

  localparam logic [6:0] O_IDLE   = 7'b1111000;
  localparam logic [6:0] O_STALL  = 7'b0011010;
  localparam logic [6:0] O_JUMP   = 7'b1111100;
  localparam logic [6:0] O_BRANCH = 7'b1111110;
  localparam logic [6:0] O_FREEZE = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WriteReg;
  logic       ID_uses_rs, ID_uses_rt;
  logic [1:0] ID_PCSrc;
  logic       EX_MemRead, EX_RegWrite, EX_BranchTaken;
  logic       MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic       PC_write, IFID_write, IDEX_write, EXMEM_write;
  logic       IFID_flush, IDEX_flush, MEMWB_bubble, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_PCSrc(ID_PCSrc),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IFID_write(IFID_write),
    .IDEX_write(IDEX_write), .EXMEM_write(EXMEM_write),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .MEMWB_bubble(MEMWB_bubble), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       urs, urt, exmr, exrw, br;
    logic [1:0] pcsrc;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;
  logic [15:0] stall_exp = 16'd0;
  logic [15:0] flush_exp = 16'd0;

  function automatic logic [6:0] outs();
    return {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush, MEMWB_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [1:0] pcsrc,
                         input logic exmr, input logic exrw, input logic [4:0] wr,
                         input logic br, input logic [6:0] exp);
    vec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.pcsrc = pcsrc;
    v.exmr = exmr; v.exrw = exrw; v.wr = wr; v.br = br; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic set_idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
    ID_PCSrc = 2'd0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    EX_BranchTaken = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic model_step(input logic [6:0] exp);
    if (!exp[6] && stall_exp != 16'hFFFF) stall_exp++;
    if (exp[2] && flush_exp != 16'hFFFF) flush_exp++;
  endtask

  // Called at posedge+1 with inputs applied; checks outputs mid-cycle,
  // then the counters after the next edge.
  task automatic cyc_check(input string nm, input logic [6:0] exp);
    #4;
    chk({nm, "_out"}, 32'(outs()), 32'(exp));
    @(posedge clk); #1;
    model_step(exp);
    chk({nm, "_stall_cnt"}, 32'(stall_cnt), 32'(stall_exp));
    chk({nm, "_flush_cnt"}, 32'(flush_cnt), 32'(flush_exp));
  endtask

  initial begin
    reset = 1'b0;
    set_idle();

    // Reset: combinational rules apply with state RUN, counters held at 0.
    ID_rs = 5'd8; ID_uses_rs = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
    #2;
    chk("rst_out", 32'(outs()), 32'(O_STALL));
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_stall_cnt", 32'(stall_cnt), 32'd0);
    set_idle();
    #2 reset = 1'b1;
    @(posedge clk); #1;

    //        name        rs     rt     urs urt pcsrc exmr exrw wr     br  expected
    add_vec("idle",       5'd0,  5'd0,  0,  0,  2'd0, 0,   0,   5'd0,  0,  O_IDLE);
    add_vec("lu_rs",      5'd8,  5'd3,  1,  1,  2'd0, 1,   1,   5'd8,  0,  O_STALL);
    add_vec("lu_rt",      5'd2,  5'd9,  1,  1,  2'd0, 1,   1,   5'd9,  0,  O_STALL);
    add_vec("lu_nouse",   5'd2,  5'd9,  1,  0,  2'd0, 1,   1,   5'd9,  0,  O_IDLE);
    add_vec("lu_reg0",    5'd0,  5'd0,  1,  1,  2'd0, 1,   1,   5'd0,  0,  O_IDLE);
    add_vec("jr_haz",     5'd31, 5'd0,  1,  0,  2'd2, 0,   1,   5'd31, 0,  O_STALL);
    add_vec("jr_reg0",    5'd0,  5'd0,  1,  0,  2'd2, 0,   1,   5'd0,  0,  O_JUMP);
    add_vec("j_nojr",     5'd5,  5'd0,  0,  0,  2'd1, 0,   1,   5'd5,  0,  O_JUMP);
    add_vec("br_lu",      5'd8,  5'd0,  1,  0,  2'd0, 1,   1,   5'd8,  1,  O_BRANCH);
    add_vec("br_jump",    5'd0,  5'd0,  0,  0,  2'd1, 0,   0,   5'd0,  1,  O_BRANCH);
    add_vec("lu_jump",    5'd8,  5'd0,  1,  0,  2'd1, 1,   1,   5'd8,  0,  O_STALL);
    add_vec("rw_only",    5'd8,  5'd0,  1,  0,  2'd0, 0,   1,   5'd8,  0,  O_IDLE);
    add_vec("jr_nomatch", 5'd8,  5'd0,  1,  0,  2'd2, 0,   1,   5'd7,  0,  O_JUMP);

    foreach (vq[i]) begin
      set_idle();
      ID_rs = vq[i].rs; ID_rt = vq[i].rt; ID_uses_rs = vq[i].urs; ID_uses_rt = vq[i].urt;
      ID_PCSrc = vq[i].pcsrc; EX_MemRead = vq[i].exmr; EX_RegWrite = vq[i].exrw;
      EX_WriteReg = vq[i].wr; EX_BranchTaken = vq[i].br;
      cyc_check(vq[i].name, vq[i].exp);
    end

    // Memory wait: ready low for 3 cycles then high; freeze beats branch.
    set_idle(); MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    cyc_check("mw1", O_FREEZE);
    EX_BranchTaken = 1'b1;
    cyc_check("mw2_br", O_FREEZE);
    EX_BranchTaken = 1'b0;
    cyc_check("mw3", O_FREEZE);
    dmem_ready = 1'b1;
    cyc_check("mw4_ready", O_IDLE);
    MEM_MemRead = 1'b0; dmem_ready = 1'b0;
    cyc_check("mw_back_run", O_IDLE);
    chk("mw_timeout_clear", 32'(mem_timeout), 32'd0);

    // Timeout (TIMEOUT=4): four frozen cycles, released on the fifth.
    set_idle(); MEM_MemWrite = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc_check($sformatf("to_frz%0d", k), O_FREEZE);
      chk($sformatf("to_flag%0d", k), 32'(mem_timeout), 32'd0);
    end
    cyc_check("to_release", O_IDLE);
    chk("to_flag5", 32'(mem_timeout), 32'd1);
    MEM_MemWrite = 1'b0;
    ID_PCSrc = 2'd1;
    cyc_check("to_after_jump", O_JUMP);
    chk("to_sticky", 32'(mem_timeout), 32'd1);

    // jr waits one cycle for the producing instruction, then redirects.
    set_idle(); ID_PCSrc = 2'd2; ID_rs = 5'd31; ID_uses_rs = 1'b1;
    EX_RegWrite = 1'b1; EX_WriteReg = 5'd31;
    cyc_check("jr_stall", O_STALL);
    EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    cyc_check("jr_go", O_JUMP);

    // Stall counter saturation.
    set_idle(); ID_rs = 5'd4; ID_uses_rs = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd4;
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk);
      model_step(O_STALL);
    end
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat_model", 32'(stall_exp), 32'h0000FFFF);
    cyc_check("sat_hold", O_STALL);

    // Asynchronous reset in the middle of a memory wait.
    set_idle(); MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    cyc_check("rw_enter", O_FREEZE);
    MEM_MemRead = 1'b0;
    cyc_check("rw_hold", O_FREEZE);
    #2 reset = 1'b0;
    #1;
    stall_exp = 16'd0; flush_exp = 16'd0;
    chk("rw_out", 32'(outs()), 32'(O_IDLE));
    chk("rw_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rw_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rw_timeout", 32'(mem_timeout), 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    cyc_check("rw_run", O_IDLE);
    chk("rw_timeout_after", 32'(mem_timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
